reg_file_4x4: RTL and testbench

// - Four-entry register file for the 4-bit CPU datapath.
// - Two asynchronous read ports (A, B) feed the ALU operands.
// - One synchronous write port takes the result or load data.
// - All four registers are exported directly as Q3..Q0 for debug and display.
//

---
 rtl/reg_file_4x4.sv | 89 ++++++++
 tb/tb_reg_file_4x4.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_4x4.sv
// reg_file_4x4: four-entry register file for the 4-bit CPU datapath.
// Two combinational read ports (A, B), one synchronous write port, and
// every register exported directly as Q3..Q0 for debug/display.
// Optional feature macro: WRITE_BYPASS_EN -- when defined, a read port whose
// select matches the active write select shows DATA_IN in the same cycle.
// Reset is synchronous and active-low; reset beats any write on the same edge.
module reg_file_4x4 #(
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        SEL_A,
    input  logic [1:0]        SEL_B,
    input  logic              write_en,
    input  logic [1:0]        SEL_W,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] OUT_A,
    output logic [DATA_W-1:0] OUT_B,
    output logic [DATA_W-1:0] Q3,
    output logic [DATA_W-1:0] Q2,
    output logic [DATA_W-1:0] Q1,
    output logic [DATA_W-1:0] Q0
);

    logic [DATA_W-1:0] r_regFile [4];
    logic [DATA_W-1:0] w_storedA;
    logic [DATA_W-1:0] w_storedB;

    // Storage: reset loads every entry, otherwise one enabled write per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_regFile[i] <= RESET_VAL;
            end
        end else if (write_en) begin
            r_regFile[SEL_W] <= DATA_IN;
        end
    end

    // Stored-value read muxes; every select code is decoded so no X escapes.
    always_comb begin
        w_storedA = r_regFile[0];
        w_storedB = r_regFile[0];
        case (SEL_A)
            2'd0: w_storedA = r_regFile[0];
            2'd1: w_storedA = r_regFile[1];
            2'd2: w_storedA = r_regFile[2];
            2'd3: w_storedA = r_regFile[3];
            default: w_storedA = r_regFile[0];
        endcase
        case (SEL_B)
            2'd0: w_storedB = r_regFile[0];
            2'd1: w_storedB = r_regFile[1];
            2'd2: w_storedB = r_regFile[2];
            2'd3: w_storedB = r_regFile[3];
            default: w_storedB = r_regFile[0];
        endcase
    end

`ifdef WRITE_BYPASS_EN
    logic w_bypassA;
    logic w_bypassB;

    // Forward the in-flight write to a matching read port; held off during reset
    // because the edge will load RESET_VAL, not DATA_IN.
    always_comb begin
        w_bypassA = rst_n && write_en && (SEL_A == SEL_W);
        w_bypassB = rst_n && write_en && (SEL_B == SEL_W);
        OUT_A = w_bypassA ? DATA_IN : w_storedA;
        OUT_B = w_bypassB ? DATA_IN : w_storedB;
    end
`else
    // Without forwarding the read ports always show stored contents.
    always_comb begin
        OUT_A = w_storedA;
        OUT_B = w_storedB;
    end
`endif

    // Debug taps mirror storage directly and are never bypassed.
    always_comb begin
        Q0 = r_regFile[0];
        Q1 = r_regFile[1];
        Q2 = r_regFile[2];
        Q3 = r_regFile[3];
    end

endmodule

// File: tb/tb_reg_file_4x4.sv
// tb_reg_file_4x4: randomized and directed checks of reg_file_4x4 against a
// plain array model. Honours WRITE_BYPASS_EN when the build defines it.
module tb_reg_file_4x4;

    logic       clk;
    logic       rst_n;
    logic [1:0] SEL_A;
    logic [1:0] SEL_B;
    logic       write_en;
    logic [1:0] SEL_W;
    logic [3:0] DATA_IN;
    logic [3:0] OUT_A;
    logic [3:0] OUT_B;
    logic [3:0] Q3;
    logic [3:0] Q2;
    logic [3:0] Q1;
    logic [3:0] Q0;

    int errors;
    int checks;

    // Reference model: just the four stored values.
    logic [3:0] model [4];

    reg_file_4x4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SEL_A    (SEL_A),
        .SEL_B    (SEL_B),
        .write_en (write_en),
        .SEL_W    (SEL_W),
        .DATA_IN  (DATA_IN),
        .OUT_A    (OUT_A),
        .OUT_B    (OUT_B),
        .Q3       (Q3),
        .Q2       (Q2),
        .Q1       (Q1),
        .Q0       (Q0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read-port value given the currently driven inputs.
    function automatic logic [3:0] expRead(input logic [1:0] sel);
`ifdef WRITE_BYPASS_EN
        if (rst_n && write_en && sel == SEL_W) return DATA_IN;
`endif
        return model[sel];
    endfunction

    function automatic logic [3:0] getQ(input int idx);
        case (idx)
            0: return Q0;
            1: return Q1;
            2: return Q2;
            default: return Q3;
        endcase
    endfunction

    // Drive all inputs just after an edge, then let combinational reads settle.
    task automatic applyStimulus(input logic rstn, input logic we, input logic [1:0] selW,
                                 input logic [3:0] din, input logic [1:0] selA,
                                 input logic [1:0] selB);
        rst_n    = rstn;
        write_en = we;
        SEL_W    = selW;
        DATA_IN  = din;
        SEL_A    = selA;
        SEL_B    = selB;
        #1;
    endtask

    // Take one edge, update the model by the register-file rules, sample 1ns later.
    task automatic clockEdge();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) model[i] = 4'h0;
        end else if (write_en) begin
            model[SEL_W] = DATA_IN;
        end
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0);
        clockEdge();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (getQ(i) !== 4'h0) begin
                errors++;
                $display("[TB] FAIL reset_q%0d got=%h exp=0", i, getQ(i));
            end
        end
        for (int s = 0; s < 4; s++) begin
            SEL_A = s[1:0];
            SEL_B = 2'(3 - s);
            #1;
            checks++;
            if (OUT_A !== 4'h0 || OUT_B !== 4'h0) begin
                errors++;
                $display("[TB] FAIL reset_read sel=%0d gotA=%h gotB=%h exp=0", s, OUT_A, OUT_B);
            end
        end
    endtask

    task automatic test_directed_writes();
        logic [3:0] expQ [4];
        expQ[0] = 4'b0001; expQ[1] = 4'b0010; expQ[2] = 4'b0100; expQ[3] = 4'b1000;
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 2'd0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0);
        checks++;
        if (OUT_A !== 4'b0001 || Q0 !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL write_reg0 gotA=%b gotQ0=%b exp=0001", OUT_A, Q0);
        end
        // Disabled write to reg1 must leave it at zero.
        applyStimulus(1'b1, 1'b0, 2'd1, 4'b0001, 2'd1, 2'd1);
        clockEdge();
        checks++;
        if (Q1 !== 4'h0 || OUT_A !== 4'h0) begin
            errors++;
            $display("[TB] FAIL we0_reg1 gotQ1=%h gotA=%h exp=0", Q1, OUT_A);
        end
        for (int r = 1; r < 4; r++) begin
            applyStimulus(1'b1, 1'b1, r[1:0], expQ[r], 2'd0, 2'd0);
            clockEdge();
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 2'd2, 2'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (getQ(i) !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL onehot_q%0d got=%b exp=%b", i, getQ(i), expQ[i]);
            end
        end
        checks++;
        if (OUT_A !== 4'b0100 || OUT_B !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL onehot_read gotA=%b gotB=%b expA=0100 expB=1000", OUT_A, OUT_B);
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 4'b1000, 2'd0, 2'd0);
        clockEdge();
        checks++;
        if (Q0 !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL we0_reg0 got=%b exp=0001", Q0);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] old2;
        old2 = model[2];
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hA, 2'd2, 2'd1);
        checks++;
        if (OUT_A !== expRead(2'd2) || Q2 !== old2) begin
            errors++;
            $display("[TB] FAIL bypass_pre gotA=%h expA=%h gotQ2=%h expQ2=%h",
                     OUT_A, expRead(2'd2), Q2, old2);
        end
        clockEdge();
        checks++;
        if (Q2 !== 4'hA || OUT_B !== model[1]) begin
            errors++;
            $display("[TB] FAIL bypass_post gotQ2=%h exp=a gotB=%h expB=%h", Q2, OUT_B, model[1]);
        end
    endtask

    task automatic test_reset_priority();
        applyStimulus(1'b0, 1'b1, 2'd3, 4'hF, 2'd3, 2'd3);
        checks++;
        if (OUT_A !== model[3]) begin
            errors++;
            $display("[TB] FAIL rst_no_bypass gotA=%h exp=%h", OUT_A, model[3]);
        end
        clockEdge();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (getQ(i) !== 4'h0) begin
                errors++;
                $display("[TB] FAIL rst_prio_q%0d got=%h exp=0", i, getQ(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, 1'b1, n[1:0], 4'(4'hC + n), n[1:0], 2'(n - 1));
            clockEdge();
            checks++;
            if (getQ(n) !== 4'(4'hC + n) || OUT_B !== expRead(2'(n - 1))) begin
                errors++;
                $display("[TB] FAIL b2b_%0d gotQ=%h expQ=%h gotB=%h expB=%h",
                         n, getQ(n), 4'(4'hC + n), OUT_B, expRead(2'(n - 1)));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 15) != 0), 1'($urandom), 2'($urandom),
                          4'($urandom), 2'($urandom), 2'($urandom));
            checks++;
            if (OUT_A !== expRead(SEL_A) || OUT_B !== expRead(SEL_B)) begin
                errors++;
                $display("[TB] FAIL rand_pre_%0d gotA=%h expA=%h gotB=%h expB=%h",
                         n, OUT_A, expRead(SEL_A), OUT_B, expRead(SEL_B));
            end
            clockEdge();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (getQ(i) !== model[i]) begin
                    errors++;
                    $display("[TB] FAIL rand_q%0d_%0d got=%h exp=%h", i, n, getQ(i), model[i]);
                end
            end
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 4; i++) model[i] = 4'h0;
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0);
        test_reset();
        test_directed_writes();
        test_bypass();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
